// File: rtl/flux_scheduler.sv
// rtl/flux_scheduler.sv - round-robin, quantum-limited flux scheduler for a shared actor datapath
module flux_scheduler #(
  parameter int FLUX      = 2,
  parameter int QUANTUM   = 4,
  parameter int TAG_WIDTH = $clog2(FLUX),
  parameter int CNT_WIDTH = $clog2(QUANTUM + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLUX-1:0]      empty,
  input  logic                 full,
  input  logic [FLUX-1:0]      enable,
  output logic [FLUX-1:0]      read,
  output logic                 write,
  output logic [TAG_WIDTH-1:0] tag,
  output logic                 busy
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t                 state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [TAG_WIDTH-1:0]   last_q, last_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [FLUX-1:0]        elig;
  logic                   cur_elig;
  logic                   fire;
  logic                   hit;
  logic [TAG_WIDTH-1:0]   pick;

  assign elig = enable & ~empty;

  always_comb begin
    cur_elig = 1'b0;
    for (int i = 0; i < FLUX; i++) begin
      if (tag_q == TAG_WIDTH'(i)) cur_elig = elig[i];
    end
  end

  assign fire  = (state_q == SERVE) && cur_elig && !full && !rst;
  assign write = fire;
  assign busy  = (state_q == SERVE);
  assign tag   = tag_q;

  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      read[i] = fire && (tag_q == TAG_WIDTH'(i));
    end
  end

  // Pick the eligible flux at the smallest circular distance after last_q;
  // last_q itself sits at distance FLUX, so it is only re-granted when alone.
  always_comb begin
    int best;
    int d;
    hit  = 1'b0;
    pick = '0;
    best = FLUX + 1;
    d    = 0;
    for (int j = 0; j < FLUX; j++) begin
      d = (j > int'(last_q)) ? (j - int'(last_q)) : (j + FLUX - int'(last_q));
      if (elig[j] && (d < best)) begin
        best = d;
        hit  = 1'b1;
        pick = TAG_WIDTH'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = SERVE;
          tag_d   = pick;
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      SERVE: begin
        if (fire) begin
          if (cnt_q == CNT_WIDTH'(QUANTUM - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end else if (!cur_elig) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
      last_q  <= TAG_WIDTH'(FLUX - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_flux_scheduler.sv
// tb/tb_flux_scheduler.sv - self-checking bench for flux_scheduler against a token-level model
module tb_flux_scheduler;

  localparam int QUANTUM = 4;

  logic       clk;
  logic       rst;
  logic [1:0] empty;
  logic       full;
  logic [1:0] enable;
  logic [1:0] read;
  logic       write;
  logic [0:0] tag;
  logic       busy;

  logic       rst3;
  logic [2:0] empty3;
  logic       full3;
  logic [2:0] enable3;
  logic [2:0] read3;
  logic       write3;
  logic [1:0] tag3;
  logic       busy3;

  flux_scheduler #(.FLUX(2), .QUANTUM(QUANTUM)) u_dut (
    .clk(clk), .rst(rst), .empty(empty), .full(full), .enable(enable),
    .read(read), .write(write), .tag(tag), .busy(busy)
  );

  flux_scheduler #(.FLUX(3), .QUANTUM(2)) u_dut3 (
    .clk(clk), .rst(rst3), .empty(empty3), .full(full3), .enable(enable3),
    .read(read3), .write(write3), .tag(tag3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    tokens[2];
  bit    m_busy;
  int    m_tag;
  int    m_last;
  int    m_used;
  string trace;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_trace(input string name, input string exp);
    total++;
    if (trace != exp) begin
      bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, trace, exp);
    end
  endtask

  // One clock cycle: present FIFO state, compare at negedge, advance the model over the edge.
  task automatic cycle();
    bit         e_fire;
    bit         found;
    logic [1:0] e_read;
    int         j;
    for (int i = 0; i < 2; i++) empty[i] = (tokens[i] == 0);
    @(negedge clk);
    e_fire = m_busy && enable[m_tag] && (tokens[m_tag] > 0) && !full && !rst;
    e_read = e_fire ? 2'(1 << m_tag) : 2'b00;
    check("read", int'(read), int'(e_read));
    check("write", int'(write), int'(e_fire));
    check("busy", int'(busy), int'(m_busy));
    check("tag", int'(tag), m_tag);
    if (write) trace = {trace, $sformatf("%0d", tag)};
    else if (busy) trace = {trace, "s"};
    else trace = {trace, "."};
    if (rst) begin
      m_busy = 0; m_tag = 0; m_last = 1; m_used = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= 2; k++) begin
        j = (m_last + k) % 2;
        if (!found && enable[j] && tokens[j] > 0) begin
          found = 1; m_busy = 1; m_tag = j; m_last = j; m_used = 0;
        end
      end
    end else if (e_fire) begin
      tokens[m_tag]--;
      m_used++;
      if (m_used == QUANTUM) m_busy = 0;
    end else if (!(enable[m_tag] && tokens[m_tag] > 0)) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; full = 1'b0; enable = 2'b11; empty = 2'b00;
    rst3 = 1'b1; full3 = 1'b0; enable3 = 3'b000; empty3 = 3'b111;
    tokens[0] = 8; tokens[1] = 8;
    m_busy = 0; m_tag = 0; m_last = 1; m_used = 0;
    @(posedge clk);
    #1;

    repeat (2) cycle();
    check_trace("reset_trace", "..");

    rst = 1'b0; trace = "";
    repeat (20) cycle();
    check_trace("round_robin", ".0000.1111.0000.1111");

    tokens[0] = 2; tokens[1] = 10; trace = "";
    repeat (19) cycle();
    check_trace("drain", ".00s.1111.1111.11s.");

    tokens[0] = 4; trace = "";
    for (int i = 0; i < 9; i++) begin
      full = (i >= 3 && i <= 5);
      cycle();
    end
    check_trace("backpressure", ".00sss00.");

    tokens[0] = 5; tokens[1] = 5; enable = 2'b10; trace = "";
    for (int i = 0; i < 10; i++) begin
      if (i == 7) enable = 2'b00;
      cycle();
    end
    check_trace("disable", ".1111.1s..");

    enable = 2'b11;
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 99) == 0);
      full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) enable = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 5) == 0 && tokens[i] < 12) tokens[i] += $urandom_range(1, 6);
      end
      cycle();
    end

    // FLUX=3: after reset last=2, so the search wraps to 0 first, then reaches 2.
    rst = 1'b1;
    rst3 = 1'b0; enable3 = 3'b111; empty3 = 3'b010; full3 = 1'b1;
    @(negedge clk);
    check("f3_idle_busy", int'(busy3), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("f3_grant_tag", int'(tag3), 0);
    check("f3_grant_busy", int'(busy3), 1);
    check("f3_stall_read", int'(read3), 0);
    @(posedge clk); #1;
    empty3 = 3'b011; full3 = 1'b0;
    @(negedge clk);
    check("f3_drain_write", int'(write3), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("f3_bubble_busy", int'(busy3), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("f3_second_tag", int'(tag3), 2);
    check("f3_second_write", int'(write3), 1);
    check("f3_second_read", int'(read3), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
